// File: rtl/can_frame_capture.sv
// can_frame_capture: idle-synchronised CAN frame capture with valid/ack publish buffer.
// Optional macro FRAME_OVF_EN: keep the first WIDTH bits of an over-long frame and report frame_ovf.
module can_frame_capture #(
  parameter int WIDTH     = 151,
  parameter int EOF_BITS  = 7,
  parameter int IDLE_BITS = 11,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             sp,
  input  logic             reset,
  input  logic             CAN_RX,
  input  logic             isStuff,
  input  logic             abort,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] frame,
  output logic [CNT_W-1:0] frame_len,
  output logic             frame_valid,
  output logic             frame_lost,
`ifdef FRAME_OVF_EN
  output logic             frame_ovf,
`endif
  output logic             state_busy
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    IDLE    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_EOF    = CNT_W'(EOF_BITS);
  localparam logic [CNT_W-1:0] CNT_IDLE   = CNT_W'(IDLE_BITS);
  localparam logic [WIDTH-1:0] SHIFT_ZERO = {WIDTH{1'b0}};

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] run_cnt_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CNT_W-1:0] bit_cnt_nxt_s;
  logic [CNT_W-1:0] run_cap_nxt_s;
  logic [CNT_W-1:0] run_sync_nxt_s;
  logic             full_s;
  logic             eof_s;
  logic             publish_s;
`ifdef FRAME_OVF_EN
  logic             ovf_r;
  logic             ovf_nxt_s;
`endif

  // Next-state values for a data bit, shared by SYNC and CAPTURE
  always_comb begin
    full_s        = (bit_cnt_r == CNT_FULL);
    bit_cnt_nxt_s = full_s ? bit_cnt_r : bit_cnt_r + CNT_ONE;
    run_cap_nxt_s = CAN_RX ? run_cnt_r + CNT_ONE : CNT_ZERO;
    if (!CAN_RX) begin
      run_sync_nxt_s = CNT_ZERO;
    end else if (run_cnt_r >= CNT_IDLE) begin
      run_sync_nxt_s = CNT_IDLE;
    end else begin
      run_sync_nxt_s = run_cnt_r + CNT_ONE;
    end
`ifdef FRAME_OVF_EN
    // Once full, the register freezes so the head of the frame survives
    shift_nxt_s = full_s ? shift_r : {shift_r[WIDTH-2:0], CAN_RX};
    ovf_nxt_s   = ovf_r | full_s;
`else
    shift_nxt_s = {shift_r[WIDTH-2:0], CAN_RX};
`endif
    eof_s     = CAN_RX && (run_cap_nxt_s == CNT_EOF);
    publish_s = !frame_valid || frame_ack;
  end

  // Capture FSM, publish buffer and valid/ack handshake
  always_ff @(posedge sp) begin
    if (!reset) begin
      state_r     <= SYNC;
      shift_r     <= SHIFT_ZERO;
      bit_cnt_r   <= CNT_ZERO;
      run_cnt_r   <= CNT_ZERO;
      frame       <= SHIFT_ZERO;
      frame_len   <= CNT_ZERO;
      frame_valid <= 1'b0;
      frame_lost  <= 1'b0;
      state_busy  <= 1'b0;
`ifdef FRAME_OVF_EN
      ovf_r       <= 1'b0;
      frame_ovf   <= 1'b0;
`endif
    end else begin
      if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
        frame_lost  <= 1'b0;
`ifdef FRAME_OVF_EN
        frame_ovf   <= 1'b0;
`endif
      end
      if (abort) begin
        state_r    <= SYNC;
        shift_r    <= SHIFT_ZERO;
        bit_cnt_r  <= CNT_ZERO;
        run_cnt_r  <= CNT_ZERO;
        state_busy <= 1'b0;
`ifdef FRAME_OVF_EN
        ovf_r      <= 1'b0;
`endif
      end else if (!isStuff) begin
        case (state_r)
          SYNC: begin
            run_cnt_r <= run_sync_nxt_s;
            if (run_sync_nxt_s == CNT_IDLE) begin
              state_r <= IDLE;
            end
          end
          IDLE: begin
            if (!CAN_RX) begin
              shift_r    <= SHIFT_ZERO;
              bit_cnt_r  <= CNT_ONE;
              run_cnt_r  <= CNT_ZERO;
              state_r    <= CAPTURE;
              state_busy <= 1'b1;
            end
          end
          CAPTURE: begin
            shift_r <= shift_nxt_s;
            if (eof_s) begin
              state_r    <= IDLE;
              state_busy <= 1'b0;
              bit_cnt_r  <= CNT_ZERO;
              run_cnt_r  <= CNT_ZERO;
`ifdef FRAME_OVF_EN
              ovf_r      <= 1'b0;
`endif
              // A pending unacknowledged frame wins; the new one is dropped
              if (publish_s) begin
                frame       <= shift_nxt_s;
                frame_len   <= bit_cnt_nxt_s;
                frame_valid <= 1'b1;
                frame_lost  <= 1'b0;
`ifdef FRAME_OVF_EN
                frame_ovf   <= ovf_nxt_s;
`endif
              end else begin
                frame_lost <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_nxt_s;
              run_cnt_r <= run_cap_nxt_s;
`ifdef FRAME_OVF_EN
              ovf_r     <= ovf_nxt_s;
`endif
            end
          end
          default: begin
            state_r    <= SYNC;
            run_cnt_r  <= CNT_ZERO;
            state_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_frame_capture.sv
// tb_can_frame_capture: random frames checked against a bit-queue reference model on a
// default-width instance and a 16-bit instance that exercises the overflow behaviour.
module tb_can_frame_capture;
  localparam int WA = 151;
  localparam int WB = 16;
  localparam int CA = $clog2(WA + 1);
  localparam int CB = $clog2(WB + 1);
`ifdef FRAME_OVF_EN
  localparam bit KEEP_FIRST = 1'b1;
`else
  localparam bit KEEP_FIRST = 1'b0;
`endif

  logic          sp = 1'b0;
  logic          reset, CAN_RX, isStuff, abort, frame_ack;
  logic [WA-1:0] frame_a;
  logic [CA-1:0] frame_len_a;
  logic          frame_valid_a, frame_lost_a, state_busy_a;
  logic [WB-1:0] frame_b;
  logic [CB-1:0] frame_len_b;
  logic          frame_valid_b, frame_lost_b, state_busy_b;
`ifdef FRAME_OVF_EN
  logic          frame_ovf_a, frame_ovf_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit pub_q[$];
  bit cur_q[$];
  bit data_q[$];
  bit exp_valid, exp_lost, exp_ovf_a, exp_ovf_b;

  always #5 sp = ~sp;

  can_frame_capture #(.WIDTH(WA)) dut_a (
    .sp(sp), .reset(reset), .CAN_RX(CAN_RX), .isStuff(isStuff), .abort(abort),
    .frame_ack(frame_ack), .frame(frame_a), .frame_len(frame_len_a),
    .frame_valid(frame_valid_a), .frame_lost(frame_lost_a),
`ifdef FRAME_OVF_EN
    .frame_ovf(frame_ovf_a),
`endif
    .state_busy(state_busy_a)
  );

  can_frame_capture #(.WIDTH(WB)) dut_b (
    .sp(sp), .reset(reset), .CAN_RX(CAN_RX), .isStuff(isStuff), .abort(abort),
    .frame_ack(frame_ack), .frame(frame_b), .frame_len(frame_len_b),
    .frame_valid(frame_valid_b), .frame_lost(frame_lost_b),
`ifdef FRAME_OVF_EN
    .frame_ovf(frame_ovf_b),
`endif
    .state_busy(state_busy_b)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected frame: kept bits of pub_q (oldest first), newest kept bit at [0]
  function automatic logic [255:0] model_frame(input int w);
    logic [255:0] v;
    int n, first, last;
    v = '0;
    n = pub_q.size();
    if (KEEP_FIRST && n > w) begin
      first = 0;
      last  = w - 1;
    end else begin
      last  = n - 1;
      first = (n > w) ? n - w : 0;
    end
    for (int i = first; i <= last; i++) v[last - i] = pub_q[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pub();
    chk("frame_a", 256'(frame_a), model_frame(WA));
    chk("len_a", 256'(frame_len_a), 256'(imin(pub_q.size(), WA)));
    chk("valid_a", 256'(frame_valid_a), 256'(exp_valid));
    chk("lost_a", 256'(frame_lost_a), 256'(exp_lost));
    chk("frame_b", 256'(frame_b), model_frame(WB));
    chk("len_b", 256'(frame_len_b), 256'(imin(pub_q.size(), WB)));
    chk("valid_b", 256'(frame_valid_b), 256'(exp_valid));
    chk("lost_b", 256'(frame_lost_b), 256'(exp_lost));
`ifdef FRAME_OVF_EN
    chk("ovf_a", 256'(frame_ovf_a), 256'(exp_ovf_a));
    chk("ovf_b", 256'(frame_ovf_b), 256'(exp_ovf_b));
`endif
  endtask

  task automatic check_busy(input bit exp);
    chk("busy_a", 256'(state_busy_a), 256'(exp));
    chk("busy_b", 256'(state_busy_b), 256'(exp));
  endtask

  task automatic bus_bit(input bit rx, input bit stf, input bit ack, input bit ab);
    CAN_RX = rx;
    isStuff = stf;
    frame_ack = ack;
    abort = ab;
    @(posedge sp);
    #1;
    frame_ack = 1'b0;
    isStuff = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) bus_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    pub_q = {};
    exp_valid = 1'b0;
    exp_lost = 1'b0;
    exp_ovf_a = 1'b0;
    exp_ovf_b = 1'b0;
    check_pub();
    check_busy(1'b0);
    reset = 1'b1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_bit(1'b1, 1'b0, 1'b0, 1'b0);
      check_busy(1'b0);
    end
  endtask

  task automatic do_ack();
    bus_bit(1'b1, 1'b0, 1'b1, 1'b0);
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_lost = 1'b0;
      exp_ovf_a = 1'b0;
      exp_ovf_b = 1'b0;
    end
    check_pub();
  endtask

  // Random payload with recessive runs of at most five, ending dominant
  task automatic gen_data(input int n);
    int run;
    bit b;
    data_q = {};
    run = 0;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if (run == 5 || i == n - 1) b = 1'b0;
      run = b ? run + 1 : 0;
      data_q.push_back(b);
    end
  endtask

  task automatic complete(input bit ack);
    if (!exp_valid || ack) begin
      pub_q = cur_q;
      exp_valid = 1'b1;
      exp_lost = 1'b0;
      exp_ovf_a = (cur_q.size() > WA);
      exp_ovf_b = (cur_q.size() > WB);
    end else begin
      exp_lost = 1'b1;
    end
  endtask

  // SOF + data_q + EOF run, with optional stuff bits that must be invisible
  task automatic send_frame(input int stuff_every, input bit eof_stuff, input bit cap, input bit ack_last);
    cur_q = {};
    if (eof_stuff) begin
      bus_bit(1'b0, 1'b1, 1'b0, 1'b0);
      check_busy(1'b0);
    end
    cur_q.push_back(1'b0);
    bus_bit(1'b0, 1'b0, 1'b0, 1'b0);
    check_busy(cap);
    check_pub();
    foreach (data_q[i]) begin
      if (stuff_every > 0 && (i % stuff_every) == stuff_every - 1) begin
        bus_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        check_busy(cap);
      end
      cur_q.push_back(data_q[i]);
      bus_bit(data_q[i], 1'b0, 1'b0, 1'b0);
      check_busy(cap);
      check_pub();
    end
    for (int k = 0; k < 7; k++) begin
      if (eof_stuff && k == 3) begin
        bus_bit(1'b0, 1'b1, 1'b0, 1'b0);
        check_busy(cap);
      end
      cur_q.push_back(1'b1);
      bus_bit(1'b1, 1'b0, ack_last && k == 6, 1'b0);
      if (k == 6 && cap) complete(ack_last);
      check_busy(cap && k < 6);
      check_pub();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    CAN_RX = 1'b1;
    isStuff = 1'b0;
    abort = 1'b0;
    frame_ack = 1'b0;

    // Basic 28-bit frame after idle sync
    do_reset();
    send_idle(11);
    gen_data(20);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    chk("t1_len", 256'(frame_len_a), 256'(28));
    chk("t1_eof", 256'(frame_a[6:0]), 256'(7'h7F));
    chk("t1_sof", 256'(frame_a[27]), 256'(1'b0));

    // Same payload with three stuff bits inserted
    do_ack();
    send_frame(6, 1'b0, 1'b1, 1'b0);
    chk("t2_len", 256'(frame_len_a), 256'(28));
    chk("t2_eof", 256'(frame_a[6:0]), 256'(7'h7F));

    // Dominant bit before idle sync must not start capture
    do_reset();
    send_idle(10);
    bus_bit(1'b0, 1'b0, 1'b0, 1'b0);
    check_busy(1'b0);
    check_pub();
    send_idle(11);
    gen_data(12);
    send_frame(3, 1'b1, 1'b1, 1'b0);

    // Back-to-back frames without ack, then ack, then completion with ack
    do_ack();
    gen_data(15);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    gen_data(9);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    chk("t4_lost", 256'(frame_lost_a), 256'(1'b1));
    do_ack();
    chk("t4_ack_valid", 256'(frame_valid_a), 256'(1'b0));
    do_ack();
    gen_data(30);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    gen_data(11);
    send_frame(4, 1'b0, 1'b1, 1'b1);

    // Abort after ten bits, then a full frame that must be ignored until resync
    do_ack();
    gen_data(9);
    bus_bit(1'b0, 1'b0, 1'b0, 1'b0);
    foreach (data_q[i]) bus_bit(data_q[i], 1'b0, 1'b0, 1'b0);
    check_busy(1'b1);
    bus_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    check_busy(1'b0);
    check_pub();
    gen_data(20);
    send_frame(0, 1'b0, 1'b0, 1'b0);
    send_idle(11);
    gen_data(20);
    send_frame(0, 1'b0, 1'b1, 1'b0);

    // 25-bit frame overflows the 16-bit instance
    do_ack();
    gen_data(17);
    send_frame(0, 1'b0, 1'b1, 1'b0);
    chk("t6_len_b", 256'(frame_len_b), 256'(16));
`ifdef FRAME_OVF_EN
    chk("t6_ovf_b", 256'(frame_ovf_b), 256'(1'b1));
`endif

    // Randomised frames, including lengths past the default width
    for (int f = 0; f < 14; f++) begin
      gen_data($urandom_range(0, 170));
      send_frame($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) do_ack();
      send_idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
